// File: rtl/ref_pkg.sv
// Shared refresh-scheduling defaults and types, also used by the RAM and FSB controllers.
package ref_pkg;

   localparam int unsigned REF_PERIOD   = 384;
   localparam int unsigned DEBT_W       = 3;
   localparam int unsigned DEBT_MAX     = 7;
   localparam int unsigned URGENT_LEVEL = 2;
   localparam int unsigned INIT_REFS    = 8;
   localparam int unsigned INIT_W       = 4;

   typedef logic [DEBT_W-1:0] debt_t;

endpackage

// File: rtl/ref_prescaler.sv
// Refresh interval prescaler: one-cycle Tick every PERIOD cycles of CLK_FSB.
module ref_prescaler
   import ref_pkg::*;
#(
   parameter int unsigned PERIOD = REF_PERIOD
) (
   input  logic CLK_FSB,
   input  logic nRES,
   output logic Tick
);

   localparam int unsigned CNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
   localparam logic [CNT_W-1:0] RELOAD = CNT_W'(PERIOD - 1);

   logic [CNT_W-1:0] count;

   always_ff @(posedge CLK_FSB or negedge nRES) begin
      if (!nRES) begin
         count <= RELOAD;
      end else if (count == '0) begin
         count <= RELOAD;
      end else begin
         count <= count - 1'b1;
      end
   end

   assign Tick = (count == '0);

endmodule

// File: rtl/ref_sched.sv
// DRAM refresh scheduler: accrues refresh debt on ticks, retires it on RefAck rising edges.
// Optional post-reset refresh burst is enabled by defining REF_INIT_BURST_EN.
module ref_sched #(
   parameter int unsigned REF_PERIOD   = ref_pkg::REF_PERIOD,
   parameter int unsigned DEBT_W       = ref_pkg::DEBT_W,
   parameter int unsigned DEBT_MAX     = ref_pkg::DEBT_MAX,
   parameter int unsigned URGENT_LEVEL = ref_pkg::URGENT_LEVEL
`ifdef REF_INIT_BURST_EN
   ,
   parameter int unsigned INIT_REFS    = ref_pkg::INIT_REFS
`endif
) (
   input  logic              CLK_FSB,
   input  logic              nRES,
   input  logic              RefAck,
   output logic              RefReq,
   output logic              RefUrgent,
   output logic              RefOvf,
   output logic [DEBT_W-1:0] Debt
);

   import ref_pkg::*;

   localparam logic [DEBT_W-1:0] DEBT_TOP  = DEBT_W'(DEBT_MAX);
   localparam logic [DEBT_W-1:0] URGENT_AT = DEBT_W'(URGENT_LEVEL);

   logic              tick;
   logic              refAckQ;
   logic              ackPulse;
   logic              debtAck;
   logic [DEBT_W-1:0] debt;
   logic              debtReq;
   logic              debtUrgent;

   ref_prescaler #(
      .PERIOD(REF_PERIOD)
   ) uPrescaler (
      .CLK_FSB(CLK_FSB),
      .nRES   (nRES),
      .Tick   (tick)
   );

   always_ff @(posedge CLK_FSB or negedge nRES) begin
      if (!nRES) begin
         refAckQ <= 1'b0;
      end else begin
         refAckQ <= RefAck;
      end
   end

   assign ackPulse = RefAck & ~refAckQ;

`ifdef REF_INIT_BURST_EN
   logic [INIT_W-1:0] initCnt;
   logic              initBusy;

   assign initBusy = (initCnt != '0);

   // Acks pay off the init burst first; debt only sees acks once the burst is done.
   always_ff @(posedge CLK_FSB or negedge nRES) begin
      if (!nRES) begin
         initCnt <= INIT_W'(INIT_REFS);
      end else if (ackPulse && initBusy) begin
         initCnt <= initCnt - 1'b1;
      end
   end

   assign debtAck = ackPulse & ~initBusy;
`else
   assign debtAck = ackPulse;
`endif

   // A tick coinciding with an ack cancels out, so overflow is never flagged then.
   always_ff @(posedge CLK_FSB or negedge nRES) begin
      if (!nRES) begin
         debt   <= '0;
         RefOvf <= 1'b0;
      end else if (tick && !debtAck) begin
         if (debt == DEBT_TOP) begin
            RefOvf <= 1'b1;
         end else begin
            debt <= debt + 1'b1;
         end
      end else if (debtAck && !tick && (debt != '0)) begin
         debt <= debt - 1'b1;
      end
   end

   assign debtReq    = (debt != '0);
   assign debtUrgent = (debt >= URGENT_AT);
   assign Debt       = debt;

`ifdef REF_INIT_BURST_EN
   assign RefReq    = debtReq | initBusy;
   assign RefUrgent = debtUrgent | initBusy;
`else
   assign RefReq    = debtReq;
   assign RefUrgent = debtUrgent;
`endif

endmodule

// File: tb/tb_ref_sched.sv
// Scoreboard bench for ref_sched: random and directed RefAck traffic against a behavioural debt model.
module tb_ref_sched;

   import ref_pkg::*;

   logic              CLK_FSB;
   logic              nRES;
   logic              RefAck;
   logic              RefReq;
   logic              RefUrgent;
   logic              RefOvf;
   logic [DEBT_W-1:0] Debt;

   typedef struct {
      int debt;
      bit req;
      bit urg;
      bit ovf;
   } exp_t;

   exp_t expQ[$];
   int   checks = 0;
   int   errors = 0;

   int mEdges;
   int mDebt;
   int mInit;
   bit mOvf;
   bit mPrevAck;

   ref_sched dut (
      .CLK_FSB  (CLK_FSB),
      .nRES     (nRES),
      .RefAck   (RefAck),
      .RefReq   (RefReq),
      .RefUrgent(RefUrgent),
      .RefOvf   (RefOvf),
      .Debt     (Debt)
   );

   initial begin
      CLK_FSB = 1'b0;
      forever #5 CLK_FSB = ~CLK_FSB;
   end

   function automatic exp_t modelOut();
      exp_t e;
      e.debt = mDebt;
      e.req  = (mDebt > 0) || (mInit > 0);
      e.urg  = (mDebt >= int'(URGENT_LEVEL)) || (mInit > 0);
      e.ovf  = mOvf;
      return e;
   endfunction

   task automatic modelReset();
      mEdges   = 0;
      mDebt    = 0;
      mOvf     = 1'b0;
      mPrevAck = 1'b0;
`ifdef REF_INIT_BURST_EN
      mInit    = int'(INIT_REFS);
`else
      mInit    = 0;
`endif
   endtask

   // One clock edge of the refresh bookkeeping, from the rules rather than any register layout.
   task automatic modelEdge(input bit ack);
      bit tick;
      bit pulse;
      mEdges   = mEdges + 1;
      tick     = (mEdges % int'(REF_PERIOD)) == 0;
      pulse    = ack && !mPrevAck;
      mPrevAck = ack;
      if (pulse && mInit > 0) begin
         mInit = mInit - 1;
         pulse = 1'b0;
      end
      if (tick && !pulse) begin
         if (mDebt == int'(DEBT_MAX)) mOvf = 1'b1;
         else mDebt = mDebt + 1;
      end else if (pulse && !tick && mDebt > 0) begin
         mDebt = mDebt - 1;
      end
   endtask

   // Called at a negedge; drives RefAck, lets one edge happen, queues the expected state.
   task automatic step(input bit ack);
      RefAck = ack;
      @(posedge CLK_FSB);
      modelEdge(ack);
      expQ.push_back(modelOut());
      @(negedge CLK_FSB);
   endtask

   task automatic idle(input int n);
      repeat (n) step(1'b0);
   endtask

   task automatic alignAck();
      while (((mEdges + 1) % int'(REF_PERIOD)) != 0) step(1'b0);
      step(1'b1);
      step(1'b0);
   endtask

   task automatic doReset(input int holdCycles);
      bit expReq;
      #2 nRES = 1'b0;
      RefAck = 1'b0;
      #1;
`ifdef REF_INIT_BURST_EN
      expReq = 1'b1;
`else
      expReq = 1'b0;
`endif
      checks++;
      if (Debt !== '0 || RefReq !== expReq || RefUrgent !== expReq || RefOvf !== 1'b0) begin
         errors++;
         $display("FAIL reset-state: Debt=%0d req=%0b urg=%0b ovf=%0b, required Debt=0 req=%0b urg=%0b ovf=0",
                  Debt, RefReq, RefUrgent, RefOvf, expReq, expReq);
      end
      repeat (holdCycles) @(negedge CLK_FSB);
      #2 nRES = 1'b1;
      modelReset();
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge CLK_FSB);
         if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checks++;
            if (Debt !== DEBT_W'(e.debt) || RefReq !== e.req || RefUrgent !== e.urg || RefOvf !== e.ovf) begin
               errors++;
               $display("FAIL scoreboard t=%0t: Debt=%0d req=%0b urg=%0b ovf=%0b, required Debt=%0d req=%0b urg=%0b ovf=%0b",
                        $time, Debt, RefReq, RefUrgent, RefOvf, e.debt, e.req, e.urg, e.ovf);
            end
         end
      end
   end

   initial begin : stimulus
      int mode;
      nRES   = 1'b0;
      RefAck = 1'b0;
      modelReset();
      @(negedge CLK_FSB);

      // First tick, long ack hold, ack at zero debt, saturation and sticky overflow.
      doReset(3);
      idle(int'(REF_PERIOD) - 1);
      idle(1);
      repeat (5) step(1'b1);
      step(1'b0);
      step(1'b1);
      step(1'b0);
      idle(8 * int'(REF_PERIOD));
      repeat (3) begin
         step(1'b1);
         step(1'b0);
      end

      // Ack coinciding with a tick at debt 3, then at debt 7.
      doReset(2);
      idle(3 * int'(REF_PERIOD));
      alignAck();
      doReset(2);
      idle(7 * int'(REF_PERIOD));
      alignAck();
      idle(int'(REF_PERIOD));

`ifdef REF_INIT_BURST_EN
      doReset(2);
      repeat (3) begin
         step(1'b1);
         step(1'b0);
      end
      doReset(1);
      repeat (int'(INIT_REFS)) begin
         step(1'b1);
         step(1'b0);
      end
      idle(4);
`endif

      // Random phases: no acks, sparse acks, busy acks, with occasional mid-count resets.
      doReset(2);
      for (int chunk = 0; chunk < 12; chunk++) begin
         mode = int'($urandom_range(0, 2));
         if ($urandom_range(0, 5) == 0) doReset(int'($urandom_range(1, 3)));
         repeat (600) begin
            if (mode == 0) step(1'b0);
            else if (mode == 1) step($urandom_range(0, 31) == 0);
            else step($urandom_range(0, 2) == 0);
         end
      end

      @(negedge CLK_FSB);
      checks++;
      if (expQ.size() != 0) begin
         errors++;
         $display("FAIL scoreboard-drain: pending=%0d, required pending=0", expQ.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
